// File: rtl/radix2ifft4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : radix2ifft4_stream
//  Description : Streaming 4-point radix-2 inverse DFT with 1/N scaling.
//                Takes four complex frequency bins X[0..3] one per handshake,
//                runs two registered butterfly stages, then emits the four
//                time-domain samples x[0..3] one per handshake. Only one
//                frame is held at a time.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      synchronous active-low reset
//    in_valid   in   1      input bin valid
//    in_ready   out  1      block can accept a bin (LOAD state)
//    in_re      in   WIDTH  bin real part, signed
//    in_im      in   WIDTH  bin imag part, signed
//    out_valid  out  1      output sample valid (DRAIN state)
//    out_ready  in   1      downstream accepts sample
//    out_re     out  WIDTH  sample real part, signed
//    out_im     out  WIDTH  sample imag part, signed
//    out_idx    out  2      time index n of the presented sample
//    out_last   out  1      high with sample n=3
// ============================================================================
module radix2ifft4_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [1:0]       out_idx,
    output logic             out_last
);

    localparam logic [1:0] c_st_load  = 2'd0;
    localparam logic [1:0] c_st_bf1   = 2'd1;
    localparam logic [1:0] c_st_bf2   = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    // Sign-extension helpers for the growing butterfly widths.
    function automatic logic [WIDTH:0] sx1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    function automatic logic [WIDTH+1:0] sx2(input logic [WIDTH:0] v);
        return {v[WIDTH], v};
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [1:0]       r_load_cnt;
    logic [1:0]       r_out_idx;
    logic             w_in_fire;
    logic             w_out_fire;

    logic [WIDTH-1:0] r_x_re [4];
    logic [WIDTH-1:0] r_x_im [4];

    logic [WIDTH:0]   w_a0_re, w_a0_im, w_a1_re, w_a1_im;
    logic [WIDTH:0]   w_b0_re, w_b0_im, w_d_re, w_d_im;
    logic [WIDTH:0]   r_a0_re, r_a0_im, r_a1_re, r_a1_im;
    logic [WIDTH:0]   r_b0_re, r_b0_im, r_b1_re, r_b1_im;

    logic [WIDTH+1:0] w_s_re [4];
    logic [WIDTH+1:0] w_s_im [4];
    logic [WIDTH-1:0] r_y_re [4];
    logic [WIDTH-1:0] r_y_im [4];
    logic             w_unused_lsbs;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake terms are built from the state directly rather than from
    // in_ready/out_valid so the next-state block has no self-dependence.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_st_load: begin
                in_ready = 1'b1;
                if (in_valid && (r_load_cnt == 2'd3)) begin
                    w_state_next = c_st_bf1;
                end
            end
            c_st_bf1: begin
                w_state_next = c_st_bf2;
            end
            c_st_bf2: begin
                w_state_next = c_st_drain;
            end
            c_st_drain: begin
                out_valid = 1'b1;
                if (out_ready && (r_out_idx == 2'd3)) begin
                    w_state_next = c_st_load;
                end
            end
            default: begin
                w_state_next = c_st_load;
            end
        endcase
    end

    assign w_in_fire  = in_valid  && (r_state == c_st_load);
    assign w_out_fire = out_ready && (r_state == c_st_drain);

    // Both counters wrap naturally from 3 to 0, so the 4th accept and the
    // last drained sample leave them ready for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_cnt <= 2'd0;
            r_out_idx  <= 2'd0;
        end else begin
            if (w_in_fire) begin
                r_load_cnt <= r_load_cnt + 2'd1;
            end
            if (w_out_fire) begin
                r_out_idx <= r_out_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_x_re[r_load_cnt] <= in_re;
            r_x_im[r_load_cnt] <= in_im;
        end
    end

    // Stage 1: pair bins 0/2 and 1/3.
    assign w_a0_re = sx1(r_x_re[0]) + sx1(r_x_re[2]);
    assign w_a0_im = sx1(r_x_im[0]) + sx1(r_x_im[2]);
    assign w_a1_re = sx1(r_x_re[0]) - sx1(r_x_re[2]);
    assign w_a1_im = sx1(r_x_im[0]) - sx1(r_x_im[2]);
    assign w_b0_re = sx1(r_x_re[1]) + sx1(r_x_re[3]);
    assign w_b0_im = sx1(r_x_im[1]) + sx1(r_x_im[3]);
    assign w_d_re  = sx1(r_x_re[1]) - sx1(r_x_re[3]);
    assign w_d_im  = sx1(r_x_im[1]) - sx1(r_x_im[3]);

    // Inverse transform twiddle is +j: j*(re + j*im) = -im + j*re.
    // The negation cannot overflow since |D| <= 2^WIDTH - 1.
    always_ff @(posedge clk) begin
        if (r_state == c_st_bf1) begin
            r_a0_re <= w_a0_re;
            r_a0_im <= w_a0_im;
            r_a1_re <= w_a1_re;
            r_a1_im <= w_a1_im;
            r_b0_re <= w_b0_re;
            r_b0_im <= w_b0_im;
            r_b1_re <= -w_d_im;
            r_b1_im <= w_d_re;
        end
    end

    // Stage 2 at full WIDTH+2 precision.
    assign w_s_re[0] = sx2(r_a0_re) + sx2(r_b0_re);
    assign w_s_im[0] = sx2(r_a0_im) + sx2(r_b0_im);
    assign w_s_re[1] = sx2(r_a1_re) + sx2(r_b1_re);
    assign w_s_im[1] = sx2(r_a1_im) + sx2(r_b1_im);
    assign w_s_re[2] = sx2(r_a0_re) - sx2(r_b0_re);
    assign w_s_im[2] = sx2(r_a0_im) - sx2(r_b0_im);
    assign w_s_re[3] = sx2(r_a1_re) - sx2(r_b1_re);
    assign w_s_im[3] = sx2(r_a1_im) - sx2(r_b1_im);

    // Dropping the two LSBs is an arithmetic >>>2 (floor), and the 1/4
    // scaled result always fits in WIDTH bits so the top is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_y_re[i] <= '0;
                r_y_im[i] <= '0;
            end
        end else if (r_state == c_st_bf2) begin
            for (int i = 0; i < 4; i++) begin
                r_y_re[i] <= w_s_re[i][WIDTH+1:2];
                r_y_im[i] <= w_s_im[i][WIDTH+1:2];
            end
        end
    end

    assign w_unused_lsbs = ^{w_s_re[0][1:0], w_s_re[1][1:0], w_s_re[2][1:0], w_s_re[3][1:0],
                             w_s_im[0][1:0], w_s_im[1][1:0], w_s_im[2][1:0], w_s_im[3][1:0]};

    // Sample data is forced to zero whenever nothing is being presented.
    assign out_re   = out_valid ? r_y_re[r_out_idx] : '0;
    assign out_im   = out_valid ? r_y_im[r_out_idx] : '0;
    assign out_idx  = r_out_idx;
    assign out_last = out_valid && (r_out_idx == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_radix2ifft4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radix2ifft4_stream
//  Description : Directed self-checking bench for radix2ifft4_stream with
//                hand-computed expected samples (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_radix2ifft4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_re;
    logic [7:0] in_im;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_re;
    logic [7:0] out_im;
    logic [1:0] out_idx;
    logic       out_last;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] cap [4];
    bit          collect_ok;
    bit          load_ok;

    always #5 clk = ~clk;

    radix2ifft4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Expected sample word: {re, im, idx, last}.
    function automatic logic [18:0] exp_s(input int re, input int im, input int n);
        logic [7:0] r8;
        logic [7:0] i8;
        logic [1:0] n2;
        r8 = re[7:0];
        i8 = im[7:0];
        n2 = n[1:0];
        return {r8, i8, n2, (n == 3)};
    endfunction

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Streams n_bins bins; optional idle cycle between bins. Returns at the
    // negedge following the last accepting edge.
    task automatic load_bins(input logic [31:0] re_p, input logic [31:0] im_p,
                             input int n_bins, input bit gaps);
        int guard;
        load_ok = 1'b1;
        for (int i = 0; i < n_bins; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_re    = re_p[8*i +: 8];
            in_im    = im_p[8*i +: 8];
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) load_ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
    endtask

    // Waits (bounded) for out_valid, then takes 4 samples with out_ready high.
    task automatic collect;
        int guard;
        guard      = 0;
        collect_ok = 1'b1;
        out_ready  = 1'b1;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int n = 0; n < 4; n++) begin
            if (!out_valid) collect_ok = 1'b0;
            cap[n] = {out_re, out_im, out_idx, out_last};
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (out_re !== 8'd0)    begin errors++; $display("FAIL reset out_re: got %0d expected 0", out_re); end
        checks++; if (out_im !== 8'd0)    begin errors++; $display("FAIL reset out_im: got %0d expected 0", out_im); end
        checks++; if (out_idx !== 2'd0)   begin errors++; $display("FAIL reset out_idx: got %0d expected 0", out_idx); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset out_last: got %b expected 0", out_last); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic v0, v1, v2;
        load_bins(pack4(4, 0, 0, 0), 32'd0, 4, 1'b0);
        v0 = out_valid;
        @(negedge clk);
        v1 = out_valid;
        @(negedge clk);
        v2 = out_valid;
        checks++;
        if ({v0, v1, v2} !== 3'b001) begin
            errors++;
            $display("FAIL b2b latency: out_valid after k,k+1,k+2 got %b%b%b expected 001", v0, v1, v2);
        end
        collect;
        checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL b2b drain: got valid gap, expected 4 samples"); end
        for (int n = 0; n < 4; n++) begin
            logic [18:0] e;
            e = exp_s(1, 0, n);
            checks++;
            if (cap[n] !== e) begin
                errors++;
                $display("FAIL b2b sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                         n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                         $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
            end
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b return: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_twiddle;
        logic [31:0] vre [3];
        logic [31:0] vim [3];
        int er [3][4];
        int ei [3][4];
        vre = '{pack4(0, 4, 0, 0), pack4(0, 0, 0, 0), pack4(0, 0, 0, 4)};
        vim = '{pack4(0, 0, 0, 0), pack4(0, 4, 0, 0), pack4(0, 0, 0, 0)};
        er  = '{'{1, 0, -1, 0}, '{0, -1, 0, 1}, '{1, 0, -1, 0}};
        ei  = '{'{0, 1, 0, -1}, '{1, 0, -1, 0}, '{0, -1, 0, 1}};
        for (int v = 0; v < 3; v++) begin
            load_bins(vre[v], vim[v], 4, 1'b0);
            collect;
            checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL twiddle[%0d] drain: got valid gap, expected 4 samples", v); end
            for (int n = 0; n < 4; n++) begin
                logic [18:0] e;
                e = exp_s(er[v][n], ei[v][n], n);
                checks++;
                if (cap[n] !== e) begin
                    errors++;
                    $display("FAIL twiddle[%0d] sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                             v, n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                             $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_rounding;
        int er [2];
        int ei [2];
        logic [31:0] vre [2];
        logic [31:0] vim [2];
        vre = '{pack4(1, 0, 0, 0), pack4(-1, 0, 0, 0)};
        vim = '{pack4(0, 0, 0, 0), pack4(-1, 0, 0, 0)};
        er  = '{0, -1};
        ei  = '{0, -1};
        for (int v = 0; v < 2; v++) begin
            load_bins(vre[v], vim[v], 4, 1'b0);
            collect;
            checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL round[%0d] drain: got valid gap, expected 4 samples", v); end
            for (int n = 0; n < 4; n++) begin
                logic [18:0] e;
                e = exp_s(er[v], ei[v], n);
                checks++;
                if (cap[n] !== e) begin
                    errors++;
                    $display("FAIL round[%0d] sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                             v, n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                             $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_extremes;
        int val [2];
        val = '{127, -128};
        for (int v = 0; v < 2; v++) begin
            load_bins(pack4(val[v], val[v], val[v], val[v]), pack4(val[v], val[v], val[v], val[v]), 4, 1'b0);
            collect;
            checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL extreme[%0d] drain: got valid gap, expected 4 samples", v); end
            for (int n = 0; n < 4; n++) begin
                logic [18:0] e;
                e = (n == 0) ? exp_s(val[v], val[v], n) : exp_s(0, 0, n);
                checks++;
                if (cap[n] !== e) begin
                    errors++;
                    $display("FAIL extreme[%0d] sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                             v, n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                             $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
                end
            end
        end
    endtask

    // Mixed frame X = {8, 4, -4, 4j} -> x = (2,1),(4,1),(0,-1),(2,-1).
    task automatic test_in_valid_gaps;
        int er [4];
        int ei [4];
        er = '{2, 4, 0, 2};
        ei = '{1, 1, -1, -1};
        load_bins(pack4(8, 4, -4, 0), pack4(0, 0, 0, 4), 4, 1'b1);
        checks++; if (load_ok !== 1'b1) begin errors++; $display("FAIL gaps load: got in_ready low, expected accept"); end
        collect;
        checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL gaps drain: got valid gap, expected 4 samples"); end
        for (int n = 0; n < 4; n++) begin
            logic [18:0] e;
            e = exp_s(er[n], ei[n], n);
            checks++;
            if (cap[n] !== e) begin
                errors++;
                $display("FAIL gaps sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                         n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                         $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_backpressure;
        int er [4];
        int ei [4];
        int guard;
        logic [18:0] e1;
        er = '{2, 4, 0, 2};
        ei = '{1, 1, -1, -1};
        e1 = exp_s(4, 1, 1);
        load_bins(pack4(8, 4, -4, 0), pack4(0, 0, 0, 4), 4, 1'b0);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        cap[0] = {out_re, out_im, out_idx, out_last};
        @(negedge clk);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_re, out_im, out_idx, out_last} !== {1'b1, e1}) begin
                errors++;
                $display("FAIL stall cycle %0d: got valid=%b re=%0d im=%0d idx=%0d last=%b expected valid=1 re=4 im=1 idx=1 last=0",
                         s, out_valid, $signed(out_re), $signed(out_im), out_idx, out_last);
            end
        end
        out_ready = 1'b1;
        for (int n = 1; n < 4; n++) begin
            cap[n] = {out_re, out_im, out_idx, out_last};
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall return: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        for (int n = 0; n < 4; n++) begin
            logic [18:0] e;
            e = exp_s(er[n], ei[n], n);
            checks++;
            if (cap[n] !== e) begin
                errors++;
                $display("FAIL stall sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                         n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                         $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
            end
        end
    endtask

    // Garbage held on the input from BF1 through the whole drain must not
    // be taken; the following frame then shows the twiddle result intact.
    task automatic test_in_valid_during_drain;
        int er [2][4];
        int ei [2][4];
        er = '{'{1, 1, 1, 1}, '{1, 0, -1, 0}};
        ei = '{'{0, 0, 0, 0}, '{0, 1, 0, -1}};
        load_bins(pack4(4, 0, 0, 0), 32'd0, 4, 1'b0);
        in_valid = 1'b1;
        in_re    = 8'h55;
        in_im    = 8'h33;
        collect;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        for (int v = 0; v < 2; v++) begin
            if (v == 1) begin
                load_bins(pack4(0, 4, 0, 0), 32'd0, 4, 1'b0);
                collect;
            end
            checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL drain_iv[%0d] drain: got valid gap, expected 4 samples", v); end
            for (int n = 0; n < 4; n++) begin
                logic [18:0] e;
                e = exp_s(er[v][n], ei[v][n], n);
                checks++;
                if (cap[n] !== e) begin
                    errors++;
                    $display("FAIL drain_iv[%0d] sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                             v, n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                             $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int er [4];
        int ei [4];
        er = '{1, 0, -1, 0};
        ei = '{0, 1, 0, -1};
        load_bins(pack4(100, -50, 0, 0), pack4(100, -50, 0, 0), 2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_load state: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        load_bins(pack4(0, 4, 0, 0), 32'd0, 4, 1'b0);
        collect;
        checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL rst_load drain: got valid gap, expected 4 samples"); end
        for (int n = 0; n < 4; n++) begin
            logic [18:0] e;
            e = exp_s(er[n], ei[n], n);
            checks++;
            if (cap[n] !== e) begin
                errors++;
                $display("FAIL rst_load sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                         n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                         $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid_drain;
        int guard;
        load_bins(pack4(8, 4, -4, 0), pack4(0, 0, 0, 4), 4, 1'b0);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_idx} !== 3'b110) begin
            errors++;
            $display("FAIL rst_drain pre: got valid=%b idx=%0d expected valid=1 idx=2", out_valid, out_idx);
        end
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({out_valid, out_idx, in_ready, out_last} !== 5'b00010) begin
            errors++;
            $display("FAIL rst_drain post: got valid=%b idx=%0d in_ready=%b last=%b expected valid=0 idx=0 in_ready=1 last=0",
                     out_valid, out_idx, in_ready, out_last);
        end
        load_bins(pack4(4, 0, 0, 0), 32'd0, 4, 1'b0);
        collect;
        checks++; if (collect_ok !== 1'b1) begin errors++; $display("FAIL rst_drain drain: got valid gap, expected 4 samples"); end
        for (int n = 0; n < 4; n++) begin
            logic [18:0] e;
            e = exp_s(1, 0, n);
            checks++;
            if (cap[n] !== e) begin
                errors++;
                $display("FAIL rst_drain sample %0d: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                         n, $signed(cap[n][18:11]), $signed(cap[n][10:3]), cap[n][2:1], cap[n][0],
                         $signed(e[18:11]), $signed(e[10:3]), e[2:1], e[0]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;
        test_reset;
        test_back_to_back;
        test_twiddle;
        test_rounding;
        test_extremes;
        test_in_valid_gaps;
        test_backpressure;
        test_in_valid_during_drain;
        test_reset_mid_load;
        test_reset_mid_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
